// File: rtl/frac_ce_gen.sv
// frac_ce_gen: multi-channel fractional clock-enable generator.
// Each channel runs a phase accumulator modulo CLK_HZ and emits one-cycle
// ce_o pulses at an average rate of rate/CLK_HZ per clk_sys cycle. Rate
// changes are captured into a pending slot and applied on a pulse boundary
// (or immediately while the channel is idle); chg_o toggles on every change
// of the active rate.
// Optional feature macro: FRAC_CE_SYNCLOCK_EN adds sync-locked rate
// measurement on channel 0 (pulses per frame * 60, clamped to
// [MIN_HZ, CLK_HZ]). Without it sync_i and lock_en_i are ignored.
module frac_ce_gen #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CLK_HZ   = 42000000,
  parameter int unsigned MIN_HZ   = 5000000
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] rate_i,
  input  logic [CHANNELS-1:0]       rate_ld_i,
  output logic [CHANNELS-1:0]       ce_o,
  output logic [CHANNELS-1:0]       chg_o,
  input  logic                      sync_i,
  input  logic                      lock_en_i
);

  localparam int unsigned AW    = WIDTH + 1;
  localparam logic [AW-1:0]    MOD   = AW'(CLK_HZ);
  localparam logic [WIDTH-1:0] CLK_W = WIDTH'(CLK_HZ);

  // Per-channel state
  logic [AW-1:0]    acc     [CHANNELS];
  logic [WIDTH-1:0] active  [CHANNELS];
  logic [WIDTH-1:0] pending [CHANNELS];
  logic [CHANNELS-1:0] pend_v;

  // Next-state values
  logic [AW-1:0]    acc_nxt_c     [CHANNELS];
  logic [AW-1:0]    sum_c         [CHANNELS];
  logic [WIDTH-1:0] act_nxt_c     [CHANNELS];
  logic [WIDTH-1:0] pend_nxt_c    [CHANNELS];
  logic [WIDTH-1:0] cap_rate_c    [CHANNELS];
  logic [CHANNELS-1:0] cap_c;
  logic [CHANNELS-1:0] apply_c;
  logic [CHANNELS-1:0] pend_v_nxt_c;
  logic [CHANNELS-1:0] ce_nxt_c;
  logic [CHANNELS-1:0] chg_nxt_c;

  // Channel-0 lock load request and its clamped rate
  logic             lock_ld_c;
  logic [WIDTH-1:0] lock_rate_c;

  // Requests above CLK_HZ saturate to a pulse every cycle
  function automatic logic [WIDTH-1:0] clamp_rate(input logic [WIDTH-1:0] r);
    return (r > CLK_W) ? CLK_W : r;
  endfunction

`ifdef FRAC_CE_SYNCLOCK_EN
  localparam int unsigned MW = WIDTH + 6;
  localparam logic [MW-1:0] CLK_M = MW'(CLK_HZ);
  localparam logic [MW-1:0] MIN_M = MW'(MIN_HZ);

  logic             sync_q;
  logic             armed;
  logic [WIDTH-1:0] pcnt;
  logic             sync_rise_c;
  logic [MW-1:0]    meas_c;

  assign sync_rise_c = sync_i & ~sync_q;
  assign meas_c      = MW'(pcnt) * MW'(60);
  assign lock_ld_c   = sync_rise_c & lock_en_i & armed;

  // Clamp the per-frame measurement into the legal rate window
  always_comb begin
    lock_rate_c = WIDTH'(meas_c);
    if (meas_c > CLK_M) begin
      lock_rate_c = CLK_W;
    end else if (meas_c < MIN_M) begin
      lock_rate_c = WIDTH'(MIN_HZ);
    end
  end

  // Sync edge detect, arming and saturating pulse counter for channel 0
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_q <= 1'b0;
      armed  <= 1'b0;
      pcnt   <= '0;
    end else begin
      sync_q <= sync_i;
      armed  <= lock_en_i & (armed | sync_rise_c);
      if (sync_rise_c) begin
        pcnt <= '0;
      end else if (ce_o[0] && (pcnt != '1)) begin
        pcnt <= pcnt + WIDTH'(1);
      end
    end
  end
`else
  logic unused_sync;

  assign lock_ld_c   = 1'b0;
  assign lock_rate_c = '0;
  assign unused_sync = sync_i ^ lock_en_i;
`endif

  // Capture, boundary-aligned apply and accumulator step for every channel
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      cap_c[n]      = rate_ld_i[n];
      cap_rate_c[n] = clamp_rate(rate_i[n*WIDTH +: WIDTH]);
      if ((n == 0) && lock_ld_c) begin
        cap_c[n]      = 1'b1;
        cap_rate_c[n] = lock_rate_c;
      end

      apply_c[n]   = pend_v[n] && (ce_o[n] || (active[n] == '0));
      act_nxt_c[n] = apply_c[n] ? pending[n] : active[n];
      sum_c[n]     = acc[n] + {1'b0, act_nxt_c[n]};

      if (sum_c[n] >= MOD) begin
        acc_nxt_c[n] = sum_c[n] - MOD;
        ce_nxt_c[n]  = 1'b1;
      end else begin
        acc_nxt_c[n] = sum_c[n];
        ce_nxt_c[n]  = 1'b0;
      end

      chg_nxt_c[n]    = chg_o[n] ^ (apply_c[n] && (pending[n] != active[n]));
      pend_nxt_c[n]   = cap_c[n] ? cap_rate_c[n] : pending[n];
      pend_v_nxt_c[n] = cap_c[n] | (pend_v[n] & ~apply_c[n]);
    end
  end

  // Channel state registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ce_o   <= '0;
      chg_o  <= '0;
      pend_v <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        acc[n]     <= '0;
        active[n]  <= '0;
        pending[n] <= '0;
      end
    end else begin
      ce_o   <= ce_nxt_c;
      chg_o  <= chg_nxt_c;
      pend_v <= pend_v_nxt_c;
      for (int n = 0; n < CHANNELS; n++) begin
        acc[n]     <= acc_nxt_c[n];
        active[n]  <= act_nxt_c[n];
        pending[n] <= pend_nxt_c[n];
      end
    end
  end

endmodule
